// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_e : 2-bit sequencer state encoding
//   idx_width() : width of a domain index for a given domain count
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_ACK = 2'd1,
    STAGGER  = 2'd2,
    DONE     = 2'd3
  } seq_state_e;

  // A single domain still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// seq_timer: saturating up-counter with synchronous clear and terminal-count compare.
// Shared by the hold, ack-timeout and stagger phases of the reset sequencer.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clr_i : clear the count to zero on the next edge
//   tc_i  : terminal value; hit_o is high while the count equals it
//   hit_o : count == tc_i
module seq_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [CNT_WIDTH-1:0] tc_i,
  output logic                 hit_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise increment and saturate so a state never sees a wrap.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q == CNT_MAX) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = (count_q == tc_i);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_DOMAINS downstream resets one at a time after a
// hold interval, waiting for each domain's ready ack (with timeout) and a stagger
// interval between releases.
//   clk              : clock
//   reset_n          : asynchronous active-low reset (from the reset synchronizer)
//   sw_reset_req     : synchronous request to restart the whole sequence
//   domain_ack       : per-domain ready acknowledge
//   domain_rst_n_out : per-domain active-low reset
//   busy             : sequence not complete
//   all_ready        : sequence complete
//   timeout_err      : sticky, some domain missed its ack
//   timeout_domain   : index of the first domain that timed out
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter  int NUM_DOMAINS    = 4,
  parameter  int HOLD_CYCLES    = 16,
  parameter  int STAGGER_CYCLES = 8,
  parameter  int ACK_TIMEOUT    = 255,
  parameter  int CNT_WIDTH      = 8,
  localparam int IDX_W          = idx_width(NUM_DOMAINS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_out,
  output logic                   busy,
  output logic                   all_ready,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       timeout_domain
);

  // Terminal values are "count - 1": the timer reads N-1 on the N-th edge of a state.
  localparam logic [CNT_WIDTH-1:0] HOLD_TC = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_TC  = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_TC =
      (STAGGER_CYCLES > 0) ? CNT_WIDTH'(STAGGER_CYCLES - 1) : {CNT_WIDTH{1'b0}};
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE_HOT0 = NUM_DOMAINS'(1);

  seq_state_e             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] rst_n_q;
  logic                   busy_q;
  logic                   ready_q;
  logic                   err_q;
  logic [IDX_W-1:0]       err_dom_q;

  logic                   ack_sel;
  logic                   timer_hit;
  logic                   timer_clr;
  logic [CNT_WIDTH-1:0]   timer_tc;
  logic                   hold_done;
  logic                   ack_accept;
  logic                   ack_timeout;
  logic                   stag_done;
  logic [IDX_W-1:0]       idx_nxt;
  logic [NUM_DOMAINS-1:0] nxt_mask;

  seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (timer_clr),
    .tc_i  (timer_tc),
    .hit_o (timer_hit)
  );

  // Phase events and timer control; the timer restarts on every state change.
  always_comb begin
    ack_sel  = domain_ack[idx_q];
    idx_nxt  = idx_q + IDX_W'(1);
    nxt_mask = ONE_HOT0 << idx_nxt;
    case (state_q)
      HOLD:     timer_tc = HOLD_TC;
      WAIT_ACK: timer_tc = ACK_TC;
      STAGGER:  timer_tc = STAG_TC;
      DONE:     timer_tc = HOLD_TC;
      default:  timer_tc = HOLD_TC;
    endcase
    hold_done   = (state_q == HOLD) && timer_hit;
    ack_accept  = (state_q == WAIT_ACK) && (ack_sel || timer_hit);
    ack_timeout = (state_q == WAIT_ACK) && !ack_sel && timer_hit;
    stag_done   = (state_q == STAGGER) && timer_hit;
    // Zero-stagger releases the next domain on the accept edge, so clearing on
    // acceptance also restarts the ack timeout for that next domain.
    timer_clr   = sw_reset_req || hold_done || ack_accept || stag_done || (state_q == DONE);
  end

  // Sequencer FSM and all output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      rst_n_q   <= '0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else if (sw_reset_req) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      rst_n_q   <= '0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_done) begin
            rst_n_q <= rst_n_q | ONE_HOT0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_accept) begin
            // Only the first timeout is recorded.
            if (ack_timeout && !err_q) begin
              err_q     <= 1'b1;
              err_dom_q <= idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (STAGGER_CYCLES == 0) begin
              rst_n_q <= rst_n_q | nxt_mask;
              idx_q   <= idx_nxt;
            end else begin
              state_q <= STAGGER;
            end
          end
        end
        STAGGER: begin
          if (stag_done) begin
            rst_n_q <= rst_n_q | nxt_mask;
            idx_q   <= idx_nxt;
            state_q <= WAIT_ACK;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign domain_rst_n_out = rst_n_q;
  assign busy             = busy_q;
  assign all_ready        = ready_q;
  assign timeout_err      = err_q;
  assign timeout_domain   = err_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int ND     = 4;
  localparam int T_HOLD = 16;
  localparam int T_STAG = 8;
  localparam int T_TO   = 255;
  localparam int NEVER  = 1 << 30;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic [ND-1:0] domain_ack = '0;
  logic [ND-1:0] ack2 = '1;

  logic [ND-1:0] domain_rst_n_out;
  logic          busy, all_ready, timeout_err;
  logic [1:0]    timeout_domain;

  logic [ND-1:0] d2_rst;
  logic          d2_busy, d2_rdy, d2_err;
  logic [1:0]    d2_dom;

  int checks = 0;
  int errors = 0;

  // Scenario description: ack delay per domain (0 = never acks) and derived edge times.
  int dly [ND];
  int rel [ND];
  int acc [ND];
  int done_e, to_e, to_d;

  reset_sequencer dut (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req), .domain_ack(domain_ack),
    .domain_rst_n_out(domain_rst_n_out), .busy(busy), .all_ready(all_ready),
    .timeout_err(timeout_err), .timeout_domain(timeout_domain)
  );

  reset_sequencer #(.STAGGER_CYCLES(0)) dut_z (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req), .domain_ack(ack2),
    .domain_rst_n_out(d2_rst), .busy(d2_busy), .all_ready(d2_rdy),
    .timeout_err(d2_err), .timeout_domain(d2_dom)
  );

  always #5 clk = ~clk;

  // Release edge of domain k, its acceptance edge and the first timeout, by plain arithmetic.
  task automatic model_build();
    int t;
    t    = T_HOLD;
    to_e = NEVER;
    to_d = 0;
    for (int k = 0; k < ND; k++) begin
      rel[k] = t;
      if (dly[k] >= 1 && dly[k] <= T_TO) begin
        acc[k] = t + dly[k];
      end else begin
        acc[k] = t + T_TO;
        if (to_e == NEVER) begin
          to_e = acc[k];
          to_d = k;
        end
      end
      t = acc[k] + T_STAG;
    end
    done_e = acc[ND-1];
  endtask

  task automatic set_dly_all(input int v);
    for (int k = 0; k < ND; k++) dly[k] = v;
    model_build();
  endtask

  // Runs n_edges edges from "edge 0" (caller is at a negedge) and checks every output.
  task automatic run_window(input string tag, input int n_edges);
    logic [ND-1:0] exp_rst;
    logic          exp_rdy, exp_err;
    logic [1:0]    exp_dom;
    for (int e = 1; e <= n_edges; e++) begin
      for (int k = 0; k < ND; k++) begin
        if (e > rel[k] && e <= acc[k])
          domain_ack[k] = (dly[k] != 0) && (e >= rel[k] + dly[k]);
        else
          domain_ack[k] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < ND; k++) exp_rst[k] = (e >= rel[k]);
      exp_rdy = (e >= done_e);
      exp_err = (e >= to_e);
      exp_dom = exp_err ? 2'(to_d) : 2'd0;
      checks++;
      if (domain_rst_n_out !== exp_rst) begin
        errors++;
        $display("FAIL %s rst_n_out edge %0d: got %b want %b", tag, e, domain_rst_n_out, exp_rst);
      end
      checks++;
      if (all_ready !== exp_rdy || busy !== !exp_rdy) begin
        errors++;
        $display("FAIL %s ready/busy edge %0d: got %b/%b want %b/%b", tag, e, all_ready, busy, exp_rdy, !exp_rdy);
      end
      checks++;
      if (timeout_err !== exp_err || timeout_domain !== exp_dom) begin
        errors++;
        $display("FAIL %s timeout edge %0d: got %b/%0d want %b/%0d", tag, e, timeout_err, timeout_domain, exp_err, exp_dom);
      end
    end
  endtask

  // One-edge software restart; the edge it is sampled on becomes edge 0.
  task automatic start_by_sw(input string tag);
    sw_reset_req = 1'b1;
    domain_ack   = ND'($urandom_range(0, (1 << ND) - 1));
    @(posedge clk);
    @(negedge clk);
    sw_reset_req = 1'b0;
    checks++;
    if (domain_rst_n_out !== 4'b0000 || busy !== 1'b1 || all_ready !== 1'b0 ||
        timeout_err !== 1'b0 || timeout_domain !== 2'd0) begin
      errors++;
      $display("FAIL %s sw restart: got rst=%b busy=%b rdy=%b err=%b dom=%0d want 0000 1 0 0 0",
               tag, domain_rst_n_out, busy, all_ready, timeout_err, timeout_domain);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (domain_rst_n_out !== 4'b0000 || busy !== 1'b1 || all_ready !== 1'b0 ||
        timeout_err !== 1'b0 || timeout_domain !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got rst=%b busy=%b rdy=%b err=%b dom=%0d want 0000 1 0 0 0",
               domain_rst_n_out, busy, all_ready, timeout_err, timeout_domain);
    end
    checks++;
    if (d2_rst !== 4'b0000 || d2_busy !== 1'b1 || d2_rdy !== 1'b0 || d2_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values_z: got rst=%b busy=%b rdy=%b err=%b want 0000 1 0 0",
               d2_rst, d2_busy, d2_rdy, d2_err);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_nominal();
    set_dly_all(1);
    run_window("nominal", 50);
  endtask

  task automatic test_sw_restart();
    start_by_sw("sw_pulse");
    set_dly_all(1);
    run_window("sw_replay", 50);
    // Held request keeps the block in HOLD with the timer parked at zero.
    for (int i = 0; i < 20; i++) begin
      sw_reset_req = 1'b1;
      domain_ack   = ND'($urandom_range(0, (1 << ND) - 1));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (domain_rst_n_out !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL sw_held cycle %0d: got rst=%b busy=%b want 0000 1", i, domain_rst_n_out, busy);
      end
    end
    sw_reset_req = 1'b0;
    run_window("sw_held_release", 20);
  endtask

  task automatic test_timeout();
    start_by_sw("timeout");
    dly[0] = 1; dly[1] = 1; dly[2] = 0; dly[3] = 1;
    model_build();
    run_window("timeout", 305);
  endtask

  task automatic test_async_reset();
    start_by_sw("async");
    set_dly_all(1);
    run_window("async_pre", 28);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (domain_rst_n_out !== 4'b0000 || busy !== 1'b1 || all_ready !== 1'b0 ||
        timeout_err !== 1'b0 || timeout_domain !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got rst=%b busy=%b rdy=%b err=%b dom=%0d want 0000 1 0 0 0",
               domain_rst_n_out, busy, all_ready, timeout_err, timeout_domain);
    end
    #1 reset_n = 1'b1;
    run_window("async_post", 50);
  endtask

  task automatic test_sw_vs_ack();
    start_by_sw("sw_vs_ack");
    set_dly_all(1);
    run_window("sw_vs_ack_pre", 16);
    sw_reset_req = 1'b1;
    domain_ack   = '1;
    @(posedge clk);
    @(negedge clk);
    sw_reset_req = 1'b0;
    checks++;
    if (domain_rst_n_out !== 4'b0000 || busy !== 1'b1 || all_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_vs_ack: got rst=%b busy=%b rdy=%b want 0000 1 0", domain_rst_n_out, busy, all_ready);
    end
    run_window("sw_vs_ack_post", 50);
  endtask

  task automatic test_zero_stagger();
    logic [ND-1:0] exp_rst;
    logic          exp_rdy;
    start_by_sw("zero_stag");
    for (int e = 1; e <= 25; e++) begin
      domain_ack = ND'($urandom_range(0, (1 << ND) - 1));
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < ND; k++) exp_rst[k] = (e >= T_HOLD + k);
      exp_rdy = (e >= T_HOLD + ND);
      checks++;
      if (d2_rst !== exp_rst || d2_rdy !== exp_rdy || d2_busy !== !exp_rdy || d2_err !== 1'b0) begin
        errors++;
        $display("FAIL zero_stagger edge %0d: got rst=%b rdy=%b busy=%b err=%b want %b %b %b 0",
                 e, d2_rst, d2_rdy, d2_busy, d2_err, exp_rst, exp_rdy, !exp_rdy);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 6; it++) begin
      start_by_sw("random");
      for (int k = 0; k < ND; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      dly[k] = 0;
        else if (r == 1) dly[k] = T_TO + $urandom_range(1, 5);
        else if (r == 2) dly[k] = T_TO;
        else             dly[k] = $urandom_range(1, 30);
      end
      model_build();
      run_window("random", done_e + 5);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sw_restart();
    test_timeout();
    test_async_reset();
    test_sw_vs_ack();
    test_zero_stagger();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences reset release across NUM_DOMAINS downstream blocks after the chip-level reset is deasserted.
- Holds all domain resets asserted for a fixed interval, then releases domains one at a time in index order (0 first).
- After each release it waits for that domain's ready acknowledge, with a timeout, then waits a stagger interval before releasing the next domain.
- Sits directly after the async-assert/sync-deassert reset synchronizer; its reset_n input is that synchronizer's output.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset domains; must be >= 1.
- HOLD_CYCLES, 16, clock edges all domains stay in reset after reset_n rises; must be >= 1.
- STAGGER_CYCLES, 8, clock edges between an accepted ack and release of the next domain; 0 is legal.
- ACK_TIMEOUT, 255, clock edges to wait for an ack before flagging a timeout; must be >= 1.
- CNT_WIDTH, 8, timer width; must hold max(HOLD_CYCLES, STAGGER_CYCLES, ACK_TIMEOUT).

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- sw_reset_req  input  1  synchronous request to re-run the whole sequence.
- domain_ack  input  NUM_DOMAINS  per-domain ready, synchronous to clk.
- domain_rst_n_out  output  NUM_DOMAINS  per-domain active-low reset.
- busy  output  1  high whenever the sequence is not complete.
- all_ready  output  1  high in DONE.
- timeout_err  output  1  sticky flag: a domain missed its ack.
- timeout_domain  output  max(1,$clog2(NUM_DOMAINS))  index of the first domain that timed out.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0, asynchronous) sets:
  - domain_rst_n_out=0, busy=1, all_ready=0, timeout_err=0, timeout_domain=0
  - state=HOLD, timer=0, idx=0.
- HOLD:
  - timer counts edges.
  - On the HOLD_CYCLES-th edge: domain_rst_n_out[0]<=1, timer<=0, go to WAIT_ACK.
- WAIT_ACK (domain idx):
  - If domain_ack[idx]=1 on an edge, the ack is accepted.
  - Otherwise timer counts edges. On the ACK_TIMEOUT-th edge without an ack, the domain is treated as accepted. If timeout_err was 0, set timeout_err<=1 and timeout_domain<=idx; a later timeout does not overwrite timeout_domain.
- Acceptance:
  - If idx==NUM_DOMAINS-1, go to DONE: all_ready<=1, busy<=0.
  - Else if STAGGER_CYCLES==0, release idx+1 on the same edge and stay in WAIT_ACK with idx+1.
  - Else go to STAGGER with timer=0.
- STAGGER: on the STAGGER_CYCLES-th edge, domain_rst_n_out[idx+1]<=1, idx<=idx+1, go to WAIT_ACK.
- DONE:
  - Stays until sw_reset_req or reset_n.
  - domain_ack is ignored; a loss of ready does not re-sequence.
- Already-released domains stay released until a restart.
- domain_ack bits for unreleased domains, or outside WAIT_ACK, are ignored.
- sw_reset_req=1 on any edge, in any state:
  - domain_rst_n_out<=0, all_ready<=0, busy<=1, timeout_err<=0, timeout_domain<=0, state<=HOLD, timer<=0, idx<=0.
  - It takes priority over an ack or timeout on the same edge.
  - Held high, it keeps the block in HOLD with timer=0.
- reset_n asserted mid-sequence: every output returns to its reset value immediately, without a clock edge. The sequence restarts from domain 0 after release.
- Timer: unsigned CNT_WIDTH, cleared on each state entry, never wraps within a state.
- Timing, defaults, acks tied high, edges counted from reset_n release:
  - domain_rst_n_out[k] rises at edge 16+9k.
  - all_ready rises at edge 44.

Decomposition:
- Shared package/header reset_seq_pkg holds:
  - state encodings HOLD, WAIT_ACK, STAGGER, DONE (2-bit)
  - the idx-width function.
- One sub-module, seq_timer: CNT_WIDTH up-counter with clear and a terminal-count compare, reused for hold, ack timeout and stagger.
- FSM and output registers stay in reset_sequencer.

Test Plan:
- Defaults, acks tied high, release reset_n -> domain_rst_n_out rises 0001@16, 0011@25, 0111@34, 1111@43; all_ready=1 and busy=0 @44; timeout_err=0.
- domain_ack[2] stuck low, others high -> bit 2 released @34; timeout_err=1 and timeout_domain=2 @289; bit 3 released @297; all_ready @298.
- sw_reset_req one-cycle pulse in DONE -> next edge domain_rst_n_out=0000, busy=1, all_ready=0, timeout_err=0; sequence replays with the same offsets counted from the pulse edge.
- reset_n driven low during STAGGER after domain 1 (outputs 0011) -> outputs 0000 with no clock edge; after release, bit 0 rises again 16 edges later.
- sw_reset_req and domain_ack[idx] high on the same edge in WAIT_ACK -> restart wins: outputs 0000, state HOLD, no further release.
- STAGGER_CYCLES=0, acks high -> releases @16, 17, 18, 19; all_ready @20.
